rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one downstream sink between N requesters.
- Each requester sends packed-struct beats grouped into bursts.
- A grant is held for a whole burst, so beats from different requesters never interleave.
- Sits between lab traffic generators (tasks driving packed-struct payloads) and a single shared consumer.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum beats per grant; the burst is force-closed at this count.
- IDLE_TIMEOUT, 16, consecutive cycles the holder may leave valid low mid-burst before the grant is revoked.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  marks the final beat of the burst.
- req_payload  in  N_REQ x $bits(arb_payload_t)  packed beat per requester.
- req_ready  out  N_REQ  per-requester beat accept.
- out_valid  out  1  beat valid to the sink.
- out_ready  in  1  sink accept.
- out_payload  out  $bits(arb_payload_t)  forwarded beat.
- out_src  out  $clog2(N_REQ)  index of the granted requester.
- busy  out  1  high while in GRANT.
- abort  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, idle_cnt=0.
  - All outputs 0.
  - Reset mid-burst drops the grant immediately; no beat is accepted while rst=1.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, pick the first index at or after rr_ptr, searching upward with wrap.
  - Register grant_idx and go to GRANT. Arbitration latency is 1 cycle; no beat transfers in IDLE.
  - If no req_valid is high, stay in IDLE.
- GRANT (combinational forwarding, zero latency):
  - out_valid = req_valid[grant_idx].
  - out_payload = req_payload[grant_idx].
  - out_src = grant_idx.
  - req_ready[i] = out_ready && (i == grant_idx); all other req_ready are 0.
  - busy = 1.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - Requesters must hold payload and last stable while valid && !ready.
- Burst end (on a transfer):
  - Burst ends if req_last[grant_idx]=1 or beat_cnt==MAX_BURST-1.
  - On burst end: state->IDLE, rr_ptr=(grant_idx+1) mod N_REQ, beat_cnt=0.
  - Otherwise beat_cnt increments by 1.
- Timeout:
  - In GRANT, idle_cnt increments each cycle req_valid[grant_idx]=0 and clears to 0 when it is 1.
  - When idle_cnt reaches IDLE_TIMEOUT-1 with valid still low: abort=1 for that cycle, state->IDLE, rr_ptr=grant_idx+1, counters cleared.
- Simultaneous events:
  - A transfer with last=1 in the timeout cycle cannot occur, because valid is low in that cycle.
  - Last beat on beat MAX_BURST: normal end, no abort.
- Fairness:
  - After a grant to index k, index k has lowest priority at the next arbitration.
  - Every continuously requesting requester is served within N_REQ grants.
- Wrap: rr_ptr and the search wrap modulo N_REQ, including non-power-of-2 N_REQ.
- Back-to-back bursts from different requesters are separated by exactly one IDLE cycle.

Decomposition:
- Package arb_pkg:
  - typedef struct packed { logic flag; bit tag; logic [7:0] data; } arb_payload_t
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - Default MAX_BURST and IDLE_TIMEOUT constants.
- Sub-module rr_pick: combinational first-set-at-or-after-pointer search. Inputs req vector and rr_ptr; outputs idx and any. Reusable by other schedulers.

Test Plan:
- Single burst, N_REQ=4: req 2 sends 3 beats (last on the 3rd), out_ready=1.
  - Cycle 1 after valid: IDLE.
  - Next 3 cycles: out_src=2, out_payload matches each beat.
  - Then IDLE; rr_ptr=3.
- Contention: reqs 0, 1, 3 all valid, 1-beat bursts.
  - Grant order is 0, 1, 3, 0, 1, 3.
  - One IDLE cycle between each grant.
  - No req_ready to non-granted indices.
- Backpressure: req 1 bursts 2 beats, out_ready low for 3 cycles mid-burst.
  - Payload held at the output.
  - Beat count is still 2, then release.
  - No other requester gets ready.
- MAX_BURST cap: req 0 streams 10 beats with last never set.
  - Grant closes after beat 8.
  - Req 0 is re-granted only after the other valid requesters are served.
  - Remaining beats arrive in a new burst.
- Timeout: req 3 sends 1 beat, then valid low for 16 cycles.
  - abort pulses 1 cycle at the 16th idle cycle.
  - busy falls; rr_ptr=0.
- Async reset mid-burst: assert rst between clock edges during req 2's beat 2.
  - busy, out_valid and req_ready drop to 0 before the next edge.
  - After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
//   arb_payload_t : packed beat carried from each requester to the sink.
//   arb_state_t   : arbiter FSM state (IDLE waits to arbitrate, GRANT forwards beats).
//   DefMaxBurst / DefIdleTimeout : default burst cap and holder idle limit.
package arb_pkg;

  typedef struct packed {
    logic       flag;
    bit         tag;
    logic [7:0] data;
  } arb_payload_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned DefMaxBurst    = 8;
  localparam int unsigned DefIdleTimeout = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: finds the first set bit of req at or after ptr,
// searching upward and wrapping modulo N_REQ (N_REQ need not be a power of two).
//   req : request vector
//   ptr : search start index (expected < N_REQ)
//   idx : selected index (0 when any is low)
//   any : at least one request bit is set
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [PTR_W:0]     base;
  logic [PTR_W:0]     sum;

  // Doubling the vector lets a single part-select express the wrapped rotation.
  assign req_dbl = {req, req};
  assign base    = {1'b0, ptr};
  assign req_rot = req_dbl[base +: N_REQ];

  always_comb begin
    any = 1'b0;
    idx = '0;
    sum = '0;
    // Descending scan so the smallest offset from ptr is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any = 1'b1;
        sum = base + (PTR_W+1)'(k);
        if (sum >= (PTR_W+1)'(N_REQ)) begin
          sum = sum - (PTR_W+1)'(N_REQ);
        end
        idx = sum[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter sharing one sink between N_REQ requesters, holding the grant for a
// whole burst. Arbitration takes one IDLE cycle; beats then forward combinationally.
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester beat valid
//   req_last     : per-requester last-beat marker
//   req_payload  : per-requester packed beat
//   req_ready    : per-requester accept (only the granted index can see out_ready)
//   out_valid / out_ready / out_payload : forwarded beat handshake to the sink
//   out_src      : granted requester index
//   busy         : high while a grant is held
//   abort        : one-cycle pulse when the grant is revoked for idling too long
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_BURST    = DefMaxBurst,
  parameter int unsigned IDLE_TIMEOUT = DefIdleTimeout,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic         [N_REQ-1:0]       req_valid,
  input  logic         [N_REQ-1:0]       req_last,
  input  arb_payload_t [N_REQ-1:0]       req_payload,
  output logic         [N_REQ-1:0]       req_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output arb_payload_t                   out_payload,
  output logic         [PTR_W-1:0]       out_src,
  output logic                           busy,
  output logic                           abort
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [PTR_W-1:0]  ptr_after_grant;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The holder gets lowest priority at the next arbitration.
  assign ptr_after_grant = (grant_q == PTR_W'(N_REQ - 1)) ? '0 : grant_q + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    req_ready   = '0;
    out_valid   = 1'b0;
    out_payload = '0;
    out_src     = '0;
    busy        = 1'b0;
    abort       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      GRANT: begin
        busy               = 1'b1;
        out_valid          = req_valid[grant_q];
        out_payload        = req_payload[grant_q];
        out_src            = grant_q;
        req_ready[grant_q] = out_ready;

        if (req_valid[grant_q] && out_ready) begin
          idle_cnt_d = '0;
          if (req_last[grant_q] || (beat_cnt_q == BEAT_W'(MAX_BURST - 1))) begin
            state_d    = IDLE;
            rr_ptr_d   = ptr_after_grant;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end else if (!req_valid[grant_q]) begin
          if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            abort      = 1'b1;
            state_d    = IDLE;
            rr_ptr_d   = ptr_after_grant;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end else begin
          // Valid but stalled by the sink: the holder is not idle.
          idle_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule
